// File: rtl/fdct_pkg.sv
// Shared types and constants for the 8x8 forward DCT engine.
package fdct_pkg;

  // Word distance between consecutive pixel blocks and coefficient blocks.
  localparam int unsigned FDCT_BLK_STRIDE = 64;

  localparam int unsigned FDCT_ADDR_W = 18;
  localparam int unsigned FDCT_DATA_W = 16;
  localparam int unsigned FDCT_ACC_W  = 32;
  localparam int unsigned FDCT_COEF_W = 13;

  typedef enum logic [2:0] {
    S_FDCT_IDLE,
    S_FDCT_FETCH,
    S_FDCT_FETCH_DRAIN,
    S_FDCT_T,
    S_FDCT_S,
    S_FDCT_NEXT,
    S_FDCT_DONE
  } fdct_state_e;

  // Row-major index into an 8x8 array.
  function automatic logic [5:0] fdct_idx(input logic [2:0] row, input logic [2:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/fdct_8x8_if.sv
// Host/SRAM bundle around the DCT engine: start/end handshake plus the SRAM bus.
interface fdct_8x8_if;
  import fdct_pkg::*;

  logic                   fdct_start;
  logic                   fdct_end;
  logic [FDCT_ADDR_W-1:0] sram_address;
  logic [FDCT_DATA_W-1:0] sram_write_data;
  logic                   sram_we_n;
  logic [FDCT_DATA_W-1:0] sram_read_data;

  // Engine side: drives the SRAM bus and the completion pulse.
  modport master (
    input  fdct_start,
    input  sram_read_data,
    output sram_address,
    output sram_write_data,
    output sram_we_n,
    output fdct_end
  );

  // Host/memory side: issues start, returns read data, observes writes.
  modport slave (
    output fdct_start,
    output sram_read_data,
    input  sram_address,
    input  sram_write_data,
    input  sram_we_n,
    input  fdct_end
  );

endinterface

// File: rtl/fdct_coef_rom.sv
// 8x8 DCT basis table scaled by 2^12; index is k*8+n, output C[k][n].
module fdct_coef_rom
  import fdct_pkg::*;
(
  input  logic [5:0]                    idx,
  output logic signed [FDCT_COEF_W-1:0] coef
);

  localparam logic signed [12:0] C_TAB [64] = '{
    13'sd1448,  13'sd1448,  13'sd1448,  13'sd1448,  13'sd1448,  13'sd1448,  13'sd1448,  13'sd1448,
    13'sd2008,  13'sd1702,  13'sd1137,  13'sd399,  -13'sd399,  -13'sd1137, -13'sd1702, -13'sd2008,
    13'sd1892,  13'sd783,  -13'sd783,  -13'sd1892, -13'sd1892, -13'sd783,   13'sd783,   13'sd1892,
    13'sd1702, -13'sd399,  -13'sd2008, -13'sd1137,  13'sd1137,  13'sd2008,  13'sd399,  -13'sd1702,
    13'sd1448, -13'sd1448, -13'sd1448,  13'sd1448,  13'sd1448, -13'sd1448, -13'sd1448,  13'sd1448,
    13'sd1137, -13'sd2008,  13'sd399,   13'sd1702, -13'sd1702, -13'sd399,   13'sd2008, -13'sd1137,
    13'sd783,  -13'sd1892,  13'sd1892, -13'sd783,  -13'sd783,   13'sd1892, -13'sd1892,  13'sd783,
    13'sd399,  -13'sd1137,  13'sd1702, -13'sd2008,  13'sd2008, -13'sd1702,  13'sd1137, -13'sd399
  };

  // Pure table lookup, no state.
  always_comb begin
    coef = C_TAB[idx];
  end

endmodule

// File: rtl/fdct_8x8.sv
// 8x8 forward DCT over SRAM: fetch a pixel block, compute T = S*C^T (>>>8),
// then S' = C*T (>>>16) and write the 64 coefficients back, one block at a time.
module fdct_8x8
  import fdct_pkg::*;
#(
  parameter logic [17:0] PIX_BASE   = 18'd0,
  parameter logic [17:0] COEF_BASE  = 18'd76800,
  parameter int unsigned NUM_BLOCKS = 1200
) (
  input  logic                   CLOCK_50_I,
  input  logic                   reset,
  input  logic                   fdct_start,
  input  logic [FDCT_DATA_W-1:0] SRAM_read_data,
  output logic [FDCT_ADDR_W-1:0] SRAM_address,
  output logic [FDCT_DATA_W-1:0] SRAM_write_data,
  output logic                   SRAM_we_n,
  output logic                   fdct_end
);

  localparam logic [FDCT_ADDR_W-1:0] BLK_STEP = 18'(FDCT_BLK_STRIDE);

  fdct_state_e state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;     // fetch/drain cycle counter, 0..65
  logic [5:0]  elem_q, elem_d;   // output element within the current pass
  logic [3:0]  tap_q, tap_d;     // 0..7 MAC taps, 8 = store cycle
  logic [15:0] blk_q, blk_d;
  logic [FDCT_ADDR_W-1:0] pix_base_q, pix_base_d;
  logic [FDCT_ADDR_W-1:0] coef_base_q, coef_base_d;
  logic signed [FDCT_ACC_W-1:0] acc_q, acc_d;
  logic [FDCT_ADDR_W-1:0] addr_q, addr_d;
  logic [FDCT_DATA_W-1:0] wdata_q, wdata_d;
  logic we_n_q, we_n_d;
  logic end_q, end_d;

  logic signed [FDCT_DATA_W-1:0] s_buf [64];
  logic signed [FDCT_ACC_W-1:0]  t_buf [64];
  logic                          s_wr_en, t_wr_en;
  logic [5:0]                    s_wr_idx, t_wr_idx;
  logic signed [FDCT_DATA_W-1:0] s_wr_data;
  logic signed [FDCT_ACC_W-1:0]  t_wr_data;

  logic signed [FDCT_DATA_W-1:0] s_rd;
  logic signed [FDCT_ACC_W-1:0]  t_rd;
  logic [5:0]                    rom_idx;
  logic signed [FDCT_COEF_W-1:0] coef;
  logic signed [FDCT_ACC_W-1:0]  mul_a, mul_b, prod, acc_sum;

  fdct_coef_rom u_rom (
    .idx  (rom_idx),
    .coef (coef)
  );

  // Buffer reads and operand/ROM-index selection: T pass uses S[r][n] with C[k][n],
  // S pass uses T[r][l] with C[k][r]; tap counts n (T pass) or r (S pass).
  always_comb begin
    s_rd = s_buf[fdct_idx(elem_q[5:3], tap_q[2:0])];
    t_rd = t_buf[fdct_idx(tap_q[2:0], elem_q[2:0])];
    if (state_q == S_FDCT_S) begin
      rom_idx = fdct_idx(elem_q[5:3], tap_q[2:0]);
      mul_a   = t_rd;
    end else begin
      rom_idx = fdct_idx(elem_q[2:0], tap_q[2:0]);
      mul_a   = {{(FDCT_ACC_W-FDCT_DATA_W){s_rd[FDCT_DATA_W-1]}}, s_rd};
    end
  end

  // The single shared multiplier feeding the accumulator.
  always_comb begin
    mul_b   = {{(FDCT_ACC_W-FDCT_COEF_W){coef[FDCT_COEF_W-1]}}, coef};
    prod    = mul_a * mul_b;
    acc_sum = acc_q + prod;
  end

  // Next-state and next-output logic for the block sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    elem_d      = elem_q;
    tap_d       = tap_q;
    blk_d       = blk_q;
    pix_base_d  = pix_base_q;
    coef_base_d = coef_base_q;
    acc_d       = acc_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_n_d      = 1'b1;
    end_d       = 1'b0;
    s_wr_en     = 1'b0;
    s_wr_idx    = 6'd0;
    s_wr_data   = SRAM_read_data;
    t_wr_en     = 1'b0;
    t_wr_idx    = elem_q;
    t_wr_data   = acc_q >>> 8;

    case (state_q)
      S_FDCT_IDLE: begin
        if (fdct_start) begin
          state_d     = S_FDCT_FETCH;
          cnt_d       = 7'd0;
          blk_d       = 16'd0;
          pix_base_d  = PIX_BASE;
          coef_base_d = COEF_BASE;
          acc_d       = 32'sd0;
          addr_d      = PIX_BASE;
        end else begin
          state_d = S_FDCT_IDLE;
        end
      end

      // Address for pixel cnt is on the bus now; its data lands two cycles later.
      S_FDCT_FETCH: begin
        cnt_d = cnt_q + 7'd1;
        if (cnt_q >= 7'd2) begin
          s_wr_en  = 1'b1;
          s_wr_idx = 6'(cnt_q - 7'd2);
        end else begin
          s_wr_en  = 1'b0;
        end
        if (cnt_q == 7'd63) begin
          state_d = S_FDCT_FETCH_DRAIN;
        end else begin
          addr_d = pix_base_q + {11'd0, cnt_q} + 18'd1;
        end
      end

      // Collect the last two samples still in the read pipeline.
      S_FDCT_FETCH_DRAIN: begin
        cnt_d    = cnt_q + 7'd1;
        s_wr_en  = 1'b1;
        s_wr_idx = 6'(cnt_q - 7'd2);
        if (cnt_q == 7'd65) begin
          state_d = S_FDCT_T;
          elem_d  = 6'd0;
          tap_d   = 4'd0;
          acc_d   = 32'sd0;
        end else begin
          state_d = S_FDCT_FETCH_DRAIN;
        end
      end

      S_FDCT_T: begin
        if (tap_q == 4'd8) begin
          t_wr_en = 1'b1;
          acc_d   = 32'sd0;
          tap_d   = 4'd0;
          elem_d  = elem_q + 6'd1;
          if (elem_q == 6'd63) begin
            state_d = S_FDCT_S;
          end else begin
            state_d = S_FDCT_T;
          end
        end else begin
          acc_d = acc_sum;
          tap_d = tap_q + 4'd1;
        end
      end

      // The final sum is registered onto the bus on the last MAC so the write
      // is presented during the store cycle; bits [31:16] are acc >>> 16 truncated.
      S_FDCT_S: begin
        if (tap_q == 4'd8) begin
          acc_d  = 32'sd0;
          tap_d  = 4'd0;
          elem_d = elem_q + 6'd1;
          if (elem_q == 6'd63) begin
            state_d = S_FDCT_NEXT;
          end else begin
            state_d = S_FDCT_S;
          end
        end else begin
          acc_d = acc_sum;
          tap_d = tap_q + 4'd1;
          if (tap_q == 4'd7) begin
            we_n_d  = 1'b0;
            wdata_d = acc_sum[31:16];
            addr_d  = coef_base_q + {12'd0, elem_q};
          end else begin
            we_n_d  = 1'b1;
          end
        end
      end

      S_FDCT_NEXT: begin
        blk_d       = blk_q + 16'd1;
        pix_base_d  = pix_base_q + BLK_STEP;
        coef_base_d = coef_base_q + BLK_STEP;
        if ((32'(blk_q) + 32'd1) < NUM_BLOCKS) begin
          state_d = S_FDCT_FETCH;
          cnt_d   = 7'd0;
          addr_d  = pix_base_q + BLK_STEP;
        end else begin
          state_d = S_FDCT_DONE;
          end_d   = 1'b1;
        end
      end

      S_FDCT_DONE: begin
        state_d = S_FDCT_IDLE;
      end

      default: begin
        state_d = S_FDCT_IDLE;
      end
    endcase
  end

  // Sequencer state and registered SRAM/handshake outputs.
  always_ff @(posedge CLOCK_50_I or posedge reset) begin
    if (reset) begin
      state_q     <= S_FDCT_IDLE;
      cnt_q       <= 7'd0;
      elem_q      <= 6'd0;
      tap_q       <= 4'd0;
      blk_q       <= 16'd0;
      pix_base_q  <= 18'd0;
      coef_base_q <= 18'd0;
      acc_q       <= 32'sd0;
      addr_q      <= 18'd0;
      wdata_q     <= 16'd0;
      we_n_q      <= 1'b1;
      end_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      elem_q      <= elem_d;
      tap_q       <= tap_d;
      blk_q       <= blk_d;
      pix_base_q  <= pix_base_d;
      coef_base_q <= coef_base_d;
      acc_q       <= acc_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_n_q      <= we_n_d;
      end_q       <= end_d;
    end
  end

  // Pixel (S) and intermediate (T) working buffers; contents need no reset.
  always_ff @(posedge CLOCK_50_I) begin
    if (s_wr_en) begin
      s_buf[s_wr_idx] <= s_wr_data;
    end
    if (t_wr_en) begin
      t_buf[t_wr_idx] <= t_wr_data;
    end
  end

  assign SRAM_address    = addr_q;
  assign SRAM_write_data = wdata_q;
  assign SRAM_we_n       = we_n_q;
  assign fdct_end        = end_q;

endmodule

// File: tb/tb_fdct_8x8.sv
// Scoreboard bench for fdct_8x8: directed blocks, expected writes queued at
// stimulus time and popped by a monitor on every SRAM write.
module tb_fdct_8x8;
  import fdct_pkg::*;

  localparam logic [17:0] PIX_B  = 18'd512;
  localparam logic [17:0] COEF_B = 18'd76800;
  // Two blocks of FETCH 64 + DRAIN 2 + T 576 + S 576 + NEXT 1 cycles, end during DONE.
  localparam int END_LAT = 2 * (64 + 2 + 576 + 576 + 1);

  typedef struct packed {
    logic [17:0] addr;
    logic [15:0] data;
  } wr_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  int   wr_cnt;
  int   end_cnt;
  int   end_cyc;
  int   end_wr;
  wr_t  exp_q [$];
  logic [15:0] pix [128];
  logic [15:0] rd_pipe;
  int   c0 [8] = '{1448, 2008, 1892, 1702, 1448, 1137, 783, 399};

  fdct_8x8_if bus ();

  fdct_8x8 #(
    .PIX_BASE   (PIX_B),
    .COEF_BASE  (COEF_B),
    .NUM_BLOCKS (2)
  ) dut (
    .CLOCK_50_I      (clk),
    .reset           (rst),
    .fdct_start      (bus.fdct_start),
    .SRAM_read_data  (bus.sram_read_data),
    .SRAM_address    (bus.sram_address),
    .SRAM_write_data (bus.sram_write_data),
    .SRAM_we_n       (bus.sram_we_n),
    .fdct_end        (bus.fdct_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] pix_word(input logic [17:0] addr);
    if (addr >= PIX_B && addr < PIX_B + 18'd128) return pix[7'(addr - PIX_B)];
    else return 16'hDEAD;
  endfunction

  // Two-cycle read latency SRAM model.
  always @(posedge clk) begin
    rd_pipe <= pix_word(bus.sram_address);
    bus.sram_read_data <= rd_pipe;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare on every write, log completion pulses.
  always @(negedge clk) begin
    wr_t e;
    if (!rst && !bus.sram_we_n) begin
      wr_cnt = wr_cnt + 1;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(bus.sram_address), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(bus.sram_address), 32'(e.addr));
        chk("wr_data", 32'(bus.sram_write_data), 32'(e.data));
      end
    end
    if (!rst && bus.fdct_end) begin
      end_cnt = end_cnt + 1;
      end_cyc = cyc;
      end_wr  = wr_cnt;
    end
  end

  // kind 0: zeros; 1: block0 all 128, block1 all -128; 2: impulse +256 / -256 at [0][0].
  task automatic fill(input int kind);
    for (int i = 0; i < 128; i++) begin
      case (kind)
        1: pix[i] = (i < 64) ? 16'h0080 : 16'hFF80;
        2: pix[i] = (i == 0) ? 16'h0100 : ((i == 64) ? 16'hFF00 : 16'h0000);
        default: pix[i] = 16'h0000;
      endcase
    end
  endtask

  task automatic push_exp(input int kind);
    wr_t e;
    int  v;
    int  p;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 64; i++) begin
        v = 0;
        case (kind)
          1: if (i == 0) v = (b == 0) ? 1023 : -1024;
          2: begin
            p = c0[i / 8] * c0[i % 8];
            v = (b == 0) ? (p >>> 16) : ((-p) >>> 16);
          end
          default: v = 0;
        endcase
        e.addr = COEF_B + 18'(b * 64 + i);
        e.data = 16'(v);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic run(input int kind, input bit mid_start);
    int start_cyc;
    fill(kind);
    push_exp(kind);
    wr_cnt = 0; end_cnt = 0; end_cyc = 0; end_wr = 0;
    @(posedge clk); #1 bus.fdct_start = 1'b1;
    @(posedge clk); #1 bus.fdct_start = 1'b0;
    start_cyc = cyc;
    chk("first_rd_addr", 32'(bus.sram_address), 32'(PIX_B));
    if (mid_start) begin
      repeat (200) @(posedge clk);
      #1 bus.fdct_start = 1'b1;
      @(posedge clk); #1 bus.fdct_start = 1'b0;
    end
    for (int i = 0; i < 5000 && end_cnt == 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    chk("end_pulses", 32'(end_cnt), 32'd1);
    chk("write_count", 32'(wr_cnt), 32'd128);
    chk("writes_before_end", 32'(end_wr), 32'd128);
    chk("end_latency", 32'(end_cyc - start_cyc), 32'(END_LAT));
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    bit hit;
    int base;
    checks = 0; errors = 0; wr_cnt = 0; end_cnt = 0; end_cyc = 0; end_wr = 0;
    rst = 1'b1;
    bus.fdct_start = 1'b0;
    fill(0);
    @(posedge clk); #1;
    chk("rst_addr", 32'(bus.sram_address), 32'd0);
    chk("rst_wdata", 32'(bus.sram_write_data), 32'd0);
    chk("rst_we_n", 32'(bus.sram_we_n), 32'd1);
    chk("rst_end", 32'(bus.fdct_end), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    run(1, 1'b0);   // flat +128 / -128 blocks
    run(2, 1'b0);   // +/- impulse at [0][0]
    run(0, 1'b1);   // all zero, stray start during T pass

    // Abort during the S pass of block 0, after a few writes.
    fill(1);
    push_exp(1);
    wr_cnt = 0; end_cnt = 0;
    @(posedge clk); #1 bus.fdct_start = 1'b1;
    @(posedge clk); #1 bus.fdct_start = 1'b0;
    for (int i = 0; i < 2000 && wr_cnt < 3; i++) @(posedge clk);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(posedge clk); #1;
      if (bus.sram_we_n == 1'b0) hit = 1'b1;
    end
    chk("abort_in_write", 32'(hit), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_we_n", 32'(bus.sram_we_n), 32'd1);
    chk("abort_addr", 32'(bus.sram_address), 32'd0);
    chk("abort_end", 32'(bus.fdct_end), 32'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    base = wr_cnt;
    repeat (1500) @(posedge clk);
    chk("abort_no_writes", 32'(wr_cnt), 32'(base));
    chk("abort_no_end", 32'(end_cnt), 32'd0);
    run(1, 1'b0);   // fresh start restarts from block 0

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
